// File: rtl/pio_btn_pkg.sv
// Shared types and constants for the button PIO poller.
package pio_btn_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA, CLEAR} state_e;

   localparam logic [1:0] EDGE_ADDR = 2'd3;
   localparam logic [1:0] DATA_ADDR = 2'd0;
endpackage

// File: rtl/btn_event_fifo.sv
// Synchronous show-ahead FIFO; head is visible from storage, zero when empty.
module btn_event_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]                 count_q, count_d;
   logic                        do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];
   assign count   = count_q;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/pio_button_poller.sv
// Polls the button PIO edge-capture register, clears it after a read, and
// queues masked edge sets for the consumer.
module pio_button_poller
   import pio_btn_pkg::*;
#(
   parameter int POLL_INTERVAL = 50000,
   parameter int FIFO_DEPTH    = 4,
   parameter int BTN_WIDTH     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic [1:0]                  avm_address,
   output logic                        avm_chipselect,
   output logic                        avm_write_n,
   output logic [31:0]                 avm_writedata,
   input  logic [31:0]                 avm_readdata,
   input  logic [BTN_WIDTH-1:0]        btn_mask,
   input  logic                        poll_now,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [BTN_WIDTH-1:0]        evt_buttons,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int            TW         = $clog2(POLL_INTERVAL);
   localparam logic [TW-1:0] TMR_RELOAD = TW'(POLL_INTERVAL - 1);

   state_e               state_q, state_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [BTN_WIDTH-1:0] edges, masked;
   logic                 push, fifo_empty, fifo_full;
   logic                 unused_rd;

   assign edges     = avm_readdata[BTN_WIDTH-1:0];
   assign masked    = edges & btn_mask;
   assign unused_rd = ^avm_readdata;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (tmr_q == '0 || poll_now) begin
               state_d = ADDR;
               tmr_d   = TMR_RELOAD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         ADDR: state_d = DATA;
         DATA: begin
            // A full FIFO leaves the edges latched in the PIO for the next poll.
            if (edges == '0) begin
               state_d = IDLE;
            end else if (masked != '0) begin
               if (fifo_full) begin
                  state_d = IDLE;
               end else begin
                  push    = 1'b1;
                  state_d = CLEAR;
               end
            end else begin
               state_d = CLEAR;
            end
         end
         CLEAR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tmr_q   <= TMR_RELOAD;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   assign avm_address    = (state_q == IDLE) ? DATA_ADDR : EDGE_ADDR;
   assign avm_chipselect = (state_q != IDLE);
   assign avm_write_n    = (state_q != CLEAR);
   assign avm_writedata  = '0;

   btn_event_fifo #(
      .WIDTH (BTN_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (masked),
      .pop       (evt_valid && evt_ready),
      .head      (evt_buttons),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign evt_valid = !fifo_empty;
endmodule

// File: tb/tb_pio_button_poller.sv
// Bench: PIO edge-capture model, queue-based reference of the poller, directed
// scenarios with literal expectations, then randomized traffic.
module tb_pio_button_poller;
   localparam int PI    = 8;
   localparam int DEPTH = 4;
   localparam int BW    = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    avm_address;
   logic          avm_chipselect, avm_write_n;
   logic [31:0]   avm_writedata;
   logic [31:0]   rdata = '0;
   logic [BW-1:0] btn_mask = '1;
   logic          poll_now = 1'b0;
   logic          evt_valid;
   logic          evt_ready = 1'b0;
   logic [BW-1:0] evt_buttons;
   logic [2:0]    fifo_count;

   always #5 clk = ~clk;

   pio_button_poller #(.POLL_INTERVAL(PI), .FIFO_DEPTH(DEPTH), .BTN_WIDTH(BW)) dut (
      .clk            (clk),
      .reset          (reset),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write_n    (avm_write_n),
      .avm_writedata  (avm_writedata),
      .avm_readdata   (rdata),
      .btn_mask       (btn_mask),
      .poll_now       (poll_now),
      .evt_valid      (evt_valid),
      .evt_ready      (evt_ready),
      .evt_buttons    (evt_buttons),
      .fifo_count     (fifo_count)
   );

   // Button PIO: rising edges accumulate, any write to address 3 wipes them.
   logic [BW-1:0] btn = '0, btn_prev = '0, cap = '0;
   always @(posedge clk) begin
      btn_prev <= btn;
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3) cap <= '0;
      else cap <= cap | (btn & ~btn_prev);
      rdata <= (avm_chipselect && avm_address == 2'd3) ? 32'(cap) : 32'd0;
   end

   int total = 0, bad = 0, wr_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: m_step = cycles since the poll trigger (0 = waiting),
   // m_wait = idle cycles left before the timer fires, mq = event queue.
   int            m_step = 0;
   int            m_wait = PI - 1;
   logic [BW-1:0] mq[$];
   logic [BW-1:0] m_e, m_m;
   bit            m_pop, m_push;

   always @(negedge clk) begin
      if (reset) begin
         m_step = 0;
         m_wait = PI - 1;
         mq.delete();
      end
      chk("cs",      int'(avm_chipselect), int'(m_step != 0));
      chk("write_n", int'(avm_write_n),    int'(m_step != 3));
      chk("address", int'(avm_address),    (m_step != 0) ? 3 : 0);
      chk("wdata",   int'(avm_writedata),  0);
      chk("valid",   int'(evt_valid),      int'(mq.size() != 0));
      chk("buttons", int'(evt_buttons),    (mq.size() != 0) ? int'(mq[0]) : 0);
      chk("count",   int'(fifo_count),     mq.size());
      if (avm_chipselect && !avm_write_n) wr_cnt++;
      if (!reset) begin
         m_pop  = (mq.size() != 0) && evt_ready;
         m_push = 1'b0;
         case (m_step)
            0: if (m_wait == 0 || poll_now) begin m_step = 1; m_wait = PI - 1; end
               else m_wait--;
            1: m_step = 2;
            2: begin
               m_e = rdata[BW-1:0];
               m_m = m_e & btn_mask;
               if (m_e == '0 || (m_m != '0 && mq.size() == DEPTH)) m_step = 0;
               else begin m_step = 3; m_push = (m_m != '0); end
            end
            default: m_step = 0;
         endcase
         if (m_pop) void'(mq.pop_front());
         if (m_push) mq.push_back(m_m);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [BW-1:0] b);
      btn = b;
      tick();
      btn = '0;
      tick();
   endtask

   task automatic wait_step(input int s, input bit need_edge);
      int n = 0;
      while (!(m_step == s && (!need_edge || rdata[BW-1:0] != '0)) && n < 60) begin
         tick();
         n++;
      end
      chk("wait_step_in_budget", int'(n < 60), 1);
   endtask

   task automatic drain(input string name, input logic [BW-1:0] e0, input logic [BW-1:0] e1,
                        input logic [BW-1:0] e2, input logic [BW-1:0] e3, input int n);
      logic [BW-1:0] exp [4];
      exp = '{e0, e1, e2, e3};
      evt_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk(name, int'(evt_buttons), int'(exp[i]));
         tick();
      end
      evt_ready = 1'b0;
   endtask

   int w0;

   initial begin
      repeat (3) tick();
      chk("rst_valid",   int'(evt_valid), 0);
      chk("rst_count",   int'(fifo_count), 0);
      chk("rst_cs",      int'(avm_chipselect), 0);
      chk("rst_write_n", int'(avm_write_n), 1);
      chk("rst_buttons", int'(evt_buttons), 0);

      // Cycle 0 after release; timer is 5 at cycle 2 when poll_now pulses.
      reset = 1'b0;
      btn   = 4'b0010;
      tick(); tick();
      poll_now = 1'b1;
      tick();
      poll_now = 1'b0;
      chk("a_addr_cs",   int'(avm_chipselect), 1);
      chk("a_addr_adr",  int'(avm_address), 3);
      chk("a_addr_wn",   int'(avm_write_n), 1);
      tick();
      poll_now = 1'b1;
      chk("a_data_wn",   int'(avm_write_n), 1);
      tick();
      poll_now = 1'b0;
      chk("a_clear_wn",  int'(avm_write_n), 0);
      chk("a_clear_adr", int'(avm_address), 3);
      chk("a_clear_wd",  int'(avm_writedata), 0);
      chk("a_valid_t3",  int'(evt_valid), 1);
      chk("a_buttons",   int'(evt_buttons), 2);
      tick();
      chk("a_idle_cs",   int'(avm_chipselect), 0);
      repeat (7) tick();
      chk("a_no_queued_poll", int'(avm_chipselect), 0);
      tick();
      chk("a_reload_poll", int'(avm_chipselect), 1);
      btn = '0;
      drain("a_pop", 4'b0010, '0, '0, '0, 1);

      // Masked-only edge: cleared, never queued.
      btn_mask = 4'b1110;
      w0 = wr_cnt;
      press(4'b0001);
      repeat (20) tick();
      chk("b_count", int'(fifo_count), 0);
      chk("b_clears", wr_cnt - w0, 1);
      btn_mask = 4'b1111;

      // Fill the FIFO, then a held-off edge waits in the PIO until space frees.
      press(4'b0001); repeat (20) tick();
      press(4'b0010); repeat (20) tick();
      press(4'b0100); repeat (20) tick();
      press(4'b1000); repeat (20) tick();
      chk("c_full_count", int'(fifo_count), 4);
      chk("c_full_head",  int'(evt_buttons), 1);
      w0 = wr_cnt;
      press(4'b0100);
      repeat (30) tick();
      chk("c_full_count2", int'(fifo_count), 4);
      chk("c_no_clear",    wr_cnt - w0, 0);
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
      repeat (30) tick();
      chk("c_refill_count", int'(fifo_count), 4);
      chk("c_one_clear",    wr_cnt - w0, 1);
      drain("c_order", 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4);

      // Reset during CLEAR: bus idles at once, edge survives in the PIO.
      press(4'b1000);
      wait_step(3, 1'b0);
      reset = 1'b1;
      #1;
      chk("d_rst_wn",    int'(avm_write_n), 1);
      chk("d_rst_cs",    int'(avm_chipselect), 0);
      chk("d_rst_count", int'(fifo_count), 0);
      chk("d_rst_valid", int'(evt_valid), 0);
      tick(); tick();
      reset = 1'b0;
      repeat (20) tick();
      chk("d_repoll_count", int'(fifo_count), 1);
      chk("d_repoll_btn",   int'(evt_buttons), 8);
      drain("d_pop", 4'b1000, '0, '0, '0, 1);

      // Push and pop in the same cycle at count 2.
      press(4'b0001); repeat (20) tick();
      press(4'b0010); repeat (20) tick();
      chk("e_count2", int'(fifo_count), 2);
      press(4'b0100);
      wait_step(2, 1'b1);
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
      chk("e_pushpop_count", int'(fifo_count), 2);
      drain("e_order", 4'b0010, 4'b0100, '0, '0, 2);

      for (int i = 0; i < 4000; i++) begin
         btn       = BW'($urandom);
         btn_mask  = ($urandom_range(0, 3) == 0) ? BW'($urandom) : '1;
         evt_ready = ($urandom_range(0, 3) == 0);
         poll_now  = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset = 1'b0;
      poll_now = 1'b0;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
